// File: rtl/jpeg_carry_unit_arbiter.sv
// Round-robin scheduler sharing one fixed-latency add/carry unit among NREQ
// requesters. Tags for in-flight operations follow the unit through a shadow
// pipeline. Results are collected in a response FIFO whose space is reserved
// at grant time by a credit counter. A flush FSM stops issue and drains.
module jpeg_carry_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     u_valid,
  output logic [WIDTH-1:0]         u_a,
  output logic [WIDTH-1:0]         u_b,
  output logic                     u_cin,
  input  logic [WIDTH-1:0]         u_sum,
  input  logic                     u_cout,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_tag,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  input  logic                     rsp_ready,
  input  logic                     flush,
  output logic                     flush_done
);

  localparam int TAGW = $clog2(NREQ);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              state;
  logic [TAGW-1:0]     ptr;
  logic [TAGW-1:0]     idx;
  logic [TAGW-1:0]     gnt_idx;
  logic                gnt_any;
  logic                issue_en;
  logic                fire;
  logic                pop;
  logic                push;
  logic [CW-1:0]       credit;
  logic [CW-1:0]       credit_nxt;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic                sel_cin;

  logic [LAT:0]        pipe_v;
  logic [TAGW-1:0]     pipe_t [LAT+1];

  logic [TAGW-1:0]     f_tag  [DEPTH];
  logic [WIDTH-1:0]    f_sum  [DEPTH];
  logic                f_cout [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW:0]         fcnt;

  assign rsp_valid = (fcnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = pipe_v[LAT];

  // A pop frees its slot in the same cycle, so a concurrent pop lends the
  // credit to this cycle's grant; this sustains one grant per cycle.
  assign issue_en  = !rst && (state == ST_RUN) && ((credit != '0) || pop);
  assign fire      = issue_en && gnt_any;

  // Round-robin search: first valid requester at or after ptr, with wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = TAGW'((32'(ptr) + k) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // One-hot grant and the granted requester's operands.
  always_comb begin
    req_ready = '0;
    if (fire) req_ready[gnt_idx] = 1'b1;
    sel_a   = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
    sel_b   = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
    sel_cin = req_cin[gnt_idx];
  end

  // Next credit: grant consumes a FIFO slot, pop returns one.
  always_comb begin
    credit_nxt = credit;
    case ({fire, pop})
      2'b10:   credit_nxt = credit - CW'(1);
      2'b01:   credit_nxt = credit + CW'(1);
      default: credit_nxt = credit;
    endcase
  end

  // Control state: pointer, credit, unit operand registers, tag valids, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      credit  <= CW'(DEPTH);
      u_valid <= 1'b0;
      u_a     <= '0;
      u_b     <= '0;
      u_cin   <= 1'b0;
      pipe_v  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      fcnt    <= '0;
    end else begin
      credit  <= credit_nxt;
      u_valid <= fire;
      if (fire) begin
        ptr   <= TAGW'((32'(gnt_idx) + 1) % NREQ);
        u_a   <= sel_a;
        u_b   <= sel_b;
        u_cin <= sel_cin;
      end
      pipe_v <= {pipe_v[LAT-1:0], fire};
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + (AW+1)'(1);
        2'b01:   fcnt <= fcnt - (AW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Data path: tag shadow pipeline and FIFO storage (no reset needed).
  always_ff @(posedge clk) begin
    pipe_t[0] <= gnt_idx;
    for (int unsigned k = 1; k <= LAT; k++) pipe_t[k] <= pipe_t[k-1];
    if (push && !rst) begin
      f_tag[wptr]  <= pipe_t[LAT];
      f_sum[wptr]  <= u_sum;
      f_cout[wptr] <= u_cout;
    end
  end

  // Flush FSM; DONE is entered as soon as the final pop leaves everything empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (credit_nxt == CW'(DEPTH)) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_tag  = rsp_valid ? f_tag[rptr]  : '0;
  assign rsp_sum  = rsp_valid ? f_sum[rptr]  : '0;
  assign rsp_cout = rsp_valid ? f_cout[rptr] : 1'b0;

endmodule

// File: tb/tb_jpeg_carry_unit_arbiter.sv
// Directed bench for jpeg_carry_unit_arbiter: reset values, single request
// latency, round-robin streaming, credit back-pressure, flush and mid-burst reset.
module tb_jpeg_carry_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         req_cin;
  logic                    u_valid;
  logic [WIDTH-1:0]        u_a;
  logic [WIDTH-1:0]        u_b;
  logic                    u_cin;
  logic [WIDTH-1:0]        u_sum;
  logic                    u_cout;
  logic                    rsp_valid;
  logic [1:0]              rsp_tag;
  logic [WIDTH-1:0]        rsp_sum;
  logic                    rsp_cout;
  logic                    rsp_ready;
  logic                    flush;
  logic                    flush_done;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed results per requester for the operand table below.
  logic [15:0] exp_sum [4] = '{16'h0003, 16'h0001, 16'h2234, 16'h0000};
  logic [3:0]  exp_cout = 4'b1010;

  jpeg_carry_unit_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .u_valid(u_valid), .u_a(u_a), .u_b(u_b), .u_cin(u_cin),
    .u_sum(u_sum), .u_cout(u_cout),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ready(rsp_ready),
    .flush(flush), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared unit: LAT register stages after the operand registers.
  logic [WIDTH:0] unit_pipe [LAT];
  always @(posedge clk) begin
    unit_pipe[0] <= {1'b0, u_a} + {1'b0, u_b} + {{WIDTH{1'b0}}, u_cin};
    for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
  end
  assign u_sum  = unit_pipe[LAT-1][WIDTH-1:0];
  assign u_cout = unit_pipe[LAT-1][WIDTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; flush = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; flush = 1'b0;
    req_a   = {16'hFFFF, 16'h1234, 16'h8000, 16'h0001};
    req_b   = {16'h0001, 16'h0FFF, 16'h8000, 16'h0002};
    req_cin = 4'b0110;

    // Reset values, with requests pending during reset.
    cyc();
    cyc();
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_u_valid", u_valid, 1'b0);
    check("rst_u_a", u_a, 16'h0);
    check("rst_u_b", u_b, 16'h0);
    check("rst_u_cin", u_cin, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_tag", rsp_tag, 2'd0);
    check("rst_rsp_sum", rsp_sum, 16'h0);
    check("rst_rsp_cout", rsp_cout, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_credit", dut.credit, DEPTH);
    check("rst_ptr", dut.ptr, 0);

    // Single request from requester 2: latency LAT+2.
    do_reset();
    req_valid = 4'b0100;
    #1;
    check("single_grant", req_ready, 4'b0100);
    cyc(); req_valid = '0; #1;
    check("single_u_valid", u_valid, 1'b1);
    check("single_u_a", u_a, 16'h1234);
    check("single_u_b", u_b, 16'h0FFF);
    check("single_u_cin", u_cin, 1'b1);
    check("single_no_rsp_t1", rsp_valid, 1'b0);
    cyc(); #1;
    check("single_u_valid_low", u_valid, 1'b0);
    check("single_u_a_hold", u_a, 16'h1234);
    cyc(); #1;
    check("single_no_rsp_t3", rsp_valid, 1'b0);
    cyc(); rsp_ready = 1'b1; #1;
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_tag", rsp_tag, 2'd2);
    check("single_rsp_sum", rsp_sum, 16'h2234);
    check("single_rsp_cout", rsp_cout, 1'b0);
    cyc(); rsp_ready = 1'b0; #1;
    check("single_rsp_popped", rsp_valid, 1'b0);

    // All requesters valid, rsp_ready=1: one grant per cycle in order.
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      req_valid = (k < 12) ? 4'hF : 4'h0;
      #1;
      check($sformatf("stream_grant_%0d", k), req_ready, (k < 12) ? onehot(k % 4) : 4'h0);
      if (k >= 4 && k < 16) begin
        check($sformatf("stream_rsp_valid_%0d", k), rsp_valid, 1'b1);
        check($sformatf("stream_rsp_tag_%0d", k), rsp_tag, (k - 4) % 4);
        check($sformatf("stream_rsp_sum_%0d", k), rsp_sum, exp_sum[(k - 4) % 4]);
        check($sformatf("stream_rsp_cout_%0d", k), rsp_cout, exp_cout[(k - 4) % 4]);
      end
      if (k == 16) check("stream_empty", rsp_valid, 1'b0);
      cyc();
    end
    check("stream_credit_back", dut.credit, DEPTH);

    // Back-pressure: exactly DEPTH grants, then one per pop.
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("bp_grant_%0d", k), req_ready, (k < 4) ? onehot(k) : 4'h0);
      cyc();
    end
    check("bp_credit_zero", dut.credit, 0);
    check("bp_head_tag", rsp_tag, 2'd0);
    rsp_ready = 1'b1; #1;
    check("bp_pop_grant", req_ready, 4'b0001);
    cyc(); rsp_ready = 1'b0; #1;
    check("bp_no_grant_after", req_ready, 4'h0);
    check("bp_head_tag2", rsp_tag, 2'd1);
    cyc();
    req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("bp_drain_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("bp_drain_tag_%0d", k), rsp_tag, (k + 1) % 4);
      check($sformatf("bp_drain_sum_%0d", k), rsp_sum, exp_sum[(k + 1) % 4]);
      cyc();
    end
    #1;
    check("bp_drain_empty", rsp_valid, 1'b0);
    check("bp_credit_back", dut.credit, DEPTH);

    // Flush during a burst: third grant honoured in the flush cycle.
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < 11; k++) begin
      flush = (k >= 2 && k < 9);
      #1;
      case (k)
        0: check("fl_grant0", req_ready, 4'b0001);
        1: check("fl_grant1", req_ready, 4'b0010);
        2: check("fl_grant2", req_ready, 4'b0100);
        3: begin
          check("fl_no_grant", req_ready, 4'h0);
          check("fl_no_rsp", rsp_valid, 1'b0);
        end
        4, 5, 6: begin
          check($sformatf("fl_rsp_valid_%0d", k), rsp_valid, 1'b1);
          check($sformatf("fl_rsp_tag_%0d", k), rsp_tag, k - 4);
          check($sformatf("fl_drain_no_grant_%0d", k), req_ready, 4'h0);
          check($sformatf("fl_done_low_%0d", k), flush_done, 1'b0);
        end
        7, 8: begin
          check($sformatf("fl_done_%0d", k), flush_done, 1'b1);
          check($sformatf("fl_done_empty_%0d", k), rsp_valid, 1'b0);
        end
        9: begin
          check("fl_done_hold", flush_done, 1'b1);
          check("fl_done_no_grant", req_ready, 4'h0);
        end
        default: begin
          check("fl_resume_grant", req_ready, 4'b1000);
          check("fl_done_clear", flush_done, 1'b0);
        end
      endcase
      cyc();
    end
    req_valid = '0;

    // Reset with two operations in flight: nothing stale emerges.
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'hF;
    #1;
    check("rr_grant0", req_ready, 4'b0001);
    cyc(); #1;
    check("rr_grant1", req_ready, 4'b0010);
    cyc();
    req_valid = '0; rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    check("rr_credit", dut.credit, DEPTH);
    check("rr_ptr", dut.ptr, 0);
    check("rr_u_valid", u_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_no_stale_%0d", k), rsp_valid, 1'b0);
      cyc();
    end
    req_valid = 4'hF; #1;
    check("rr_grant_after", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
